// File: rtl/booth_operand_sequencer.sv
// Operand feeder for the Booth multiplier: buffers {m,r} pairs in a FIFO,
// issues one at a time with a start pulse, and retires on done or watchdog.
module booth_operand_sequencer #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_m,
    input  logic [31:0]              in_r,
    output logic [31:0]              mul_m,
    output logic [31:0]              mul_r,
    output logic                     mul_start,
    input  logic                     mul_done,
    input  logic                     err_clr,
    output logic                     busy,
    output logic                     err_timeout,
    output logic [15:0]              retired_cnt,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(MAX_WAIT);
    localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [WW-1:0]  WAIT_ONE  = WW'(1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RETIRE} state_t;

    state_t        state;
    state_t        next_state;
    logic [31:0]   mem_m [DEPTH];
    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [WW-1:0] wait_cnt;
    logic          push;
    logic          pop;
    logic          issue;
    logic          timeout;

    // Handshake: a pair transfers on any rising edge where in_valid && in_ready.
    // in_ready depends only on registered occupancy, so a full FIFO never
    // accepts even when the head is popping in the same cycle.
    assign in_ready = (fifo_count < FULL_CNT);
    assign push     = in_valid && in_ready;
    // A still-high done from the previous operation holds off the next issue.
    assign issue    = (state == IDLE) && (fifo_count != '0) && !mul_done;
    assign timeout  = (state == WAIT) && !mul_done && (wait_cnt == WAIT_LAST);
    assign pop      = (state == RETIRE) || timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (issue) next_state = START;
            START:   next_state = WAIT;
            WAIT: begin
                if (mul_done) begin
                    next_state = RETIRE;
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            RETIRE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mul_start = (state == START);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_m[wr_ptr] <= in_m;
            mem_r[wr_ptr] <= in_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_m <= '0;
            mul_r <= '0;
        end else if (issue) begin
            mul_m <= mem_m[rd_ptr];
            mul_r <= mem_r[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == START) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (timeout) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (state == RETIRE) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Randomised scoreboard bench for booth_operand_sequencer: issued pairs are
// checked against push order; counters and flags against a small model.
module tb_booth_operand_sequencer;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 40;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [31:0]            in_m = '0;
    logic [31:0]            in_r = '0;
    logic [31:0]            mul_m;
    logic [31:0]            mul_r;
    logic                   mul_start;
    logic                   mul_done = 1'b0;
    logic                   err_clr = 1'b0;
    logic                   busy;
    logic                   err_timeout;
    logic [15:0]            retired_cnt;
    logic [$clog2(DEPTH):0] fifo_count;

    booth_operand_sequencer #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_m(in_m), .in_r(in_r), .mul_m(mul_m), .mul_r(mul_r),
        .mul_start(mul_start), .mul_done(mul_done), .err_clr(err_clr),
        .busy(busy), .err_timeout(err_timeout), .retired_cnt(retired_cnt),
        .fifo_count(fifo_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // scoreboard: pairs go out in exactly the order they were accepted
    logic [63:0] exp_q[$];
    int          n_starts = 0;
    int          last_start_cyc = 0;
    bit          prev_start = 1'b0;

    always @(negedge clk) begin
        if (rst_n && mul_start) begin
            n_starts++;
            last_start_cyc = cyc;
            check("start_single_pulse", 64'(prev_start), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL start_unexpected: got mul_start=1 with pair 0x%0h, required no start (queue empty)",
                         {mul_m, mul_r});
            end else begin
                check("issue_pair", {mul_m, mul_r}, exp_q.pop_front());
            end
        end
        prev_start = rst_n && mul_start;
        if (!rst_n) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back({in_m, in_r});
    end

    // multiplier model: done arrives d cycles after start; retires iff d <= MAX_WAIT
    int done_delay = 34;
    int done_hold = 1;
    bit done_never = 1'b0;
    bit rand_resp = 1'b0;
    int exp_retired = 0;
    bit exp_err = 1'b0;
    int last_fall_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n && mul_start) begin
            int d;
            bit never;
            d = done_delay;
            never = done_never;
            if (rand_resp) begin
                never = ($urandom_range(0, 3) == 0);
                d = $urandom_range(34, MAX_WAIT);
            end
            if (never) begin
                exp_err = 1'b1;
            end else begin
                repeat (d) @(posedge clk);
                #1 mul_done = 1'b1;
                if (d <= MAX_WAIT) exp_retired++;
                repeat (done_hold) @(posedge clk);
                #1 mul_done = 1'b0;
                last_fall_cyc = cyc;
            end
        end
    end

    // driver tasks
    task automatic push_pair(input logic [31:0] m, input logic [31:0] r);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_m = m;
        in_r = r;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("push_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while ((busy || fifo_count != 0) && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
        check(name, 64'(busy || fifo_count != 0), 64'd0);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic wait_starts(input int target);
        int i;
        i = 0;
        while (n_starts < target && i < 300) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("start_seen", 64'(n_starts >= target), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int push_cyc;
        int s;
        int base;
        int i;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_operands", {mul_m, mul_r}, 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_retired", 64'(retired_cnt), 64'd0);

        // single op, done 36 cycles after start
        done_delay = 36;
        done_hold = 1;
        base = n_starts;
        push_pair(32'h0000_0003, 32'hFFFF_FFFE);
        push_cyc = cyc;
        wait_starts(base + 1);
        check("start_latency", 64'(last_start_cyc - push_cyc), 64'd1);
        wait_idle("t1_drain");
        check("t1_retired", 64'(retired_cnt), 64'(exp_retired));
        check("t1_retired_one", 64'(retired_cnt), 64'd1);
        check("t1_fifo_count", 64'(fifo_count), 64'd0);
        check("t1_operand_hold", {mul_m, mul_r}, 64'h0000_0003_FFFF_FFFE);
        check("t1_err", 64'(err_timeout), 64'd0);

        // fill, backpressure and watchdog with a silent multiplier
        done_never = 1'b1;
        for (int k = 0; k < DEPTH; k++) push_pair(32'h100 + k, 32'h200 + k);
        check("full_count", 64'(fifo_count), 64'(DEPTH));
        check("full_in_ready", 64'(in_ready), 64'd0);
        s = last_start_cyc;
        in_valid = 1'b1;
        in_m = 32'h104;
        in_r = 32'h204;
        i = 0;
        while (fifo_count == DEPTH && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("timeout_latency", 64'(cyc - s), 64'(MAX_WAIT + 1));
        check("timeout_count", 64'(fifo_count), 64'(DEPTH - 1));
        check("timeout_err", 64'(err_timeout), 64'd1);
        check("timeout_retired", 64'(retired_cnt), 64'(exp_retired));
        check("timeout_in_ready", 64'(in_ready), 64'd1);
        push_pair(32'h104, 32'h204);
        push_pair(32'h105, 32'h205);
        wait_idle("t2_drain");
        check("t2_err", 64'(err_timeout), 64'(exp_err));
        check("t2_retired", 64'(retired_cnt), 64'(exp_retired));
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("err_clr", 64'(err_timeout), 64'd0);
        exp_err = 1'b0;

        // done arriving on the last allowed WAIT cycle still retires
        done_never = 1'b0;
        done_delay = MAX_WAIT;
        push_pair(32'hA5A5_0001, 32'h8000_0000);
        wait_idle("limit_drain");
        check("limit_err", 64'(err_timeout), 64'd0);
        check("limit_retired", 64'(retired_cnt), 64'(exp_retired));

        // done held high blocks reissue until it falls
        done_delay = 34;
        done_hold = 5;
        base = n_starts;
        push_pair(32'h11, 32'h22);
        push_pair(32'h33, 32'h44);
        wait_starts(base + 2);
        check("reissue_after_done_fall", 64'(last_start_cyc - last_fall_cyc), 64'd1);
        wait_idle("t4_drain");
        check("t4_retired", 64'(retired_cnt), 64'(exp_retired));
        done_hold = 1;

        // reset in the middle of WAIT with entries queued
        done_never = 1'b1;
        push_pair(32'h61, 32'h71);
        push_pair(32'h62, 32'h72);
        push_pair(32'h63, 32'h73);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_retired = 0;
        exp_err = 1'b0;
        check("midrst_mul_start", 64'(mul_start), 64'd0);
        check("midrst_operands", {mul_m, mul_r}, 64'd0);
        check("midrst_fifo_count", 64'(fifo_count), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_retired", 64'(retired_cnt), 64'd0);
        base = n_starts;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_start", 64'(n_starts - base), 64'd0);

        // back-to-back ordering across pointer wrap
        done_never = 1'b0;
        done_delay = 34;
        base = n_starts;
        for (int k = 0; k < 5; k++) push_pair(32'(2 * k + 1), 32'(2 * k + 2));
        wait_idle("t5_drain");
        check("t5_starts", 64'(n_starts - base), 64'd5);
        check("t5_retired", 64'(retired_cnt), 64'd5);

        // randomised traffic, some operations never answered
        rand_resp = 1'b1;
        for (int k = 0; k < 14; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            push_pair($urandom, $urandom);
        end
        wait_idle("rand_drain");
        rand_resp = 1'b0;
        check("rand_retired", 64'(retired_cnt), 64'(exp_retired));
        check("rand_err", 64'(err_timeout), 64'(exp_err));
        check("all_issued", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
